// File: rtl/busca_instrucao.sv
// -----------------------------------------------------------------------------
// busca_instrucao -- instruction fetch stage
//
// Fetches one 32-bit instruction word per request from an instruction memory.
// It presents the word, together with its address, on registered outputs that
// feed the field decoder. The stage honours a downstream stall (parar) and a
// one-cycle redirect pulse (desvio) from branch/jump resolution.
//
// Parameters
//   PC_RESET      fetch address loaded on reset
//
// Ports
//   clock         single clock, all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   mem_req       instruction-memory read request (registered)
//   mem_endereco  word address of the outstanding request (registered)
//   mem_pronto    memory returns mem_dado this cycle
//   mem_dado      instruction word from memory
//   parar         downstream stall: the decoder cannot accept a new word
//   desvio        redirect pulse (taken branch/jump)
//   desvio_alvo   redirect target address (low two bits are ignored)
//   instrucao     registered instruction word
//   pc_atual      address of instrucao
//   pc_mais4      pc_atual + 4, combinational, wraps modulo 2^32
//   valida        instrucao/pc_atual hold a live instruction
//
// States
//   OCIOSO    one idle cycle after reset, then start fetching
//   BUSCA     request outstanding at pc; accept the word when it returns
//   SEGURA    word returned while stalled; it waits in an internal buffer
//   DESCARTE  redirect arrived while a request was still pending; wait for
//             that stale word, drop it, then fetch at the new target
// -----------------------------------------------------------------------------
module busca_instrucao #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_endereco,
  input  logic        mem_pronto,
  input  logic [31:0] mem_dado,
  input  logic        parar,
  input  logic        desvio,
  input  logic [31:0] desvio_alvo,
  output logic [31:0] instrucao,
  output logic [31:0] pc_atual,
  output logic [31:0] pc_mais4,
  output logic        valida
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    BUSCA    = 2'd1,
    SEGURA   = 2'd2,
    DESCARTE = 2'd3
  } estado_t;

  estado_t     estado;

  // Address of the next word to fetch. In DESCARTE this already holds the
  // redirect target while mem_endereco keeps the stale address still on the bus.
  logic [31:0] pc;
  logic [31:0] pc_prox;

  // Word captured while the decoder was stalled, and the address it came from.
  logic [31:0] buf_dado;
  logic [31:0] buf_endereco;

  // Redirect target forced onto a word boundary.
  logic [31:0] alvo;

  assign pc_prox  = pc + 32'd4;
  assign alvo     = desvio_alvo & 32'hFFFF_FFFC;
  assign pc_mais4 = pc_atual + 32'd4;

  // mem_req and mem_endereco are registered alongside the state so that the
  // memory sees glitch-free request signals. Every transition into BUSCA
  // therefore loads mem_endereco with the address that BUSCA will request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      pc           <= PC_RESET;
      mem_req      <= 1'b0;
      mem_endereco <= PC_RESET;
      instrucao    <= 32'h0;
      pc_atual     <= 32'h0;
      valida       <= 1'b0;
      buf_dado     <= 32'h0;
      buf_endereco <= 32'h0;
    end else begin
      case (estado)
        OCIOSO: begin
          estado  <= BUSCA;
          mem_req <= 1'b1;
          if (desvio) begin
            pc           <= alvo;
            mem_endereco <= alvo;
            valida       <= 1'b0;
          end else begin
            mem_endereco <= pc;
            if (!parar) begin
              valida <= 1'b0;
            end
          end
        end

        BUSCA: begin
          if (desvio) begin
            // The redirect squashes the presented word and any returning word.
            valida <= 1'b0;
            pc     <= alvo;
            if (mem_pronto) begin
              // The pending request completed this cycle, so the target can
              // be requested straight away.
              mem_endereco <= alvo;
            end else begin
              // The memory still owes us a word for the old address; keep
              // that request on the bus until it arrives, then drop it.
              estado <= DESCARTE;
            end
          end else if (mem_pronto) begin
            pc           <= pc_prox;
            mem_endereco <= pc_prox;
            if (parar) begin
              // Decoder is busy: park the word instead of overwriting the
              // word it is still holding.
              buf_dado     <= mem_dado;
              buf_endereco <= pc;
              mem_req      <= 1'b0;
              estado       <= SEGURA;
            end else begin
              instrucao <= mem_dado;
              pc_atual  <= pc;
              valida    <= 1'b1;
            end
          end else if (!parar) begin
            // The decoder took the presented word and nothing new arrived.
            valida <= 1'b0;
          end
        end

        SEGURA: begin
          // mem_pronto is ignored here: no request is outstanding.
          if (desvio) begin
            valida       <= 1'b0;
            pc           <= alvo;
            mem_endereco <= alvo;
            mem_req      <= 1'b1;
            estado       <= BUSCA;
          end else if (!parar) begin
            instrucao    <= buf_dado;
            pc_atual     <= buf_endereco;
            valida       <= 1'b1;
            mem_endereco <= pc;
            mem_req      <= 1'b1;
            estado       <= BUSCA;
          end
        end

        DESCARTE: begin
          // A further redirect only retargets; the stale request stays on the
          // bus until the memory answers it.
          if (desvio) begin
            valida <= 1'b0;
            pc     <= alvo;
          end
          if (mem_pronto) begin
            // Stale word dropped. If a redirect lands in the same cycle, its
            // target is the next address to fetch.
            estado       <= BUSCA;
            mem_endereco <= desvio ? alvo : pc;
          end
        end

        default: begin
          estado  <= OCIOSO;
          mem_req <= 1'b0;
          valida  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// -----------------------------------------------------------------------------
// tb_busca_instrucao -- self-checking bench for busca_instrucao
//
// A behavioural memory answers requests after a programmable latency with a
// tagged word derived from the requested address. Every word the memory hands
// out that must reach the decoder is pushed to a scoreboard queue, together
// with the address the program order says it must come from. A word leaves
// the queue when the decoder consumes it (valida=1 with parar=0 at the edge).
// A redirect squashes every word not yet consumed.
// -----------------------------------------------------------------------------
module tb_busca_instrucao;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_endereco;
  logic        mem_pronto = 1'b0;
  logic [31:0] mem_dado = 32'h0;
  logic        parar = 1'b0;
  logic        desvio = 1'b0;
  logic [31:0] desvio_alvo = 32'h0;
  logic [31:0] instrucao;
  logic [31:0] pc_atual;
  logic [31:0] pc_mais4;
  logic        valida;

  busca_instrucao dut (
    .clock        (clock),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_endereco (mem_endereco),
    .mem_pronto   (mem_pronto),
    .mem_dado     (mem_dado),
    .parar        (parar),
    .desvio       (desvio),
    .desvio_alvo  (desvio_alvo),
    .instrucao    (instrucao),
    .pc_atual     (pc_atual),
    .pc_mais4     (pc_mais4),
    .valida       (valida)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          passed = 0;

  // memory model state
  int          lat = 0;
  int          cnt = 0;
  bit          fresh = 1'b1;
  bit          mem_en = 1'b1;
  bit          spurious = 1'b0;
  bit          discard = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] fetch_pc = 32'h0;

  // outputs observed at the start of the latest step
  logic        obs_req;
  logic [31:0] obs_end;
  logic [31:0] obs_instr;
  logic [31:0] obs_pc;
  logic [31:0] obs_pc4;
  logic        obs_valida;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  // One clock cycle: observe, score consumption, run the memory, drive inputs.
  task automatic step(input logic p, input logic d, input logic [31:0] alvo);
    logic pr;
    exp_t e;
    @(negedge clock);
    obs_req    = mem_req;
    obs_end    = mem_endereco;
    obs_instr  = instrucao;
    obs_pc     = pc_atual;
    obs_pc4    = pc_mais4;
    obs_valida = valida;

    if (obs_valida && !p) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL consume: got word pc=%h instr=%h, required none pending", obs_pc, obs_instr);
      end else begin
        e = exp_q.pop_front();
        if (obs_instr !== e.word || obs_pc !== e.addr || obs_pc4 !== e.addr + 32'd4) begin
          $display("FAIL consume: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                   obs_pc, obs_instr, obs_pc4, e.addr, e.word, e.addr + 32'd4);
        end else begin
          passed++;
          $display("consume pc=%h instr=%h", obs_pc, obs_instr);
        end
      end
    end

    pr = 1'b0;
    if (!obs_req) begin
      fresh = 1'b1;
    end else begin
      if (fresh || obs_end !== last_addr) begin
        cnt       = 0;
        fresh     = 1'b0;
        last_addr = obs_end;
      end else begin
        cnt++;
      end
      pr = mem_en && (cnt >= lat);
      if (pr) fresh = 1'b1;
    end

    if (pr) begin
      if (d || discard) begin
        discard = 1'b0;
      end else begin
        total++;
        if (obs_end !== fetch_pc) begin
          $display("FAIL fetch_addr: got mem_endereco=%h, required %h", obs_end, fetch_pc);
        end else begin
          passed++;
        end
        exp_q.push_back('{addr: fetch_pc, word: tag(fetch_pc)});
        fetch_pc = fetch_pc + 32'd4;
      end
    end

    if (d) begin
      exp_q.delete();
      fetch_pc = alvo & 32'hFFFF_FFFC;
      if (obs_req && !pr) discard = 1'b1;
    end

    parar       = p;
    desvio      = d;
    desvio_alvo = alvo;
    mem_pronto  = pr || (spurious && !obs_req);
    mem_dado    = pr ? tag(obs_end) : 32'hDEAD_BEEF;
  endtask

  // Asserts reset a little after the falling edge, checks the outputs clear
  // at once, then releases it on the next falling edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (instrucao !== 32'h0 || pc_atual !== 32'h0 || valida !== 1'b0 ||
        mem_req !== 1'b0 || pc_mais4 !== 32'h4) begin
      $display("FAIL reset_outputs: got instr=%h pc=%h valida=%b req=%b pc4=%h, required 0 0 0 0 4",
               instrucao, pc_atual, valida, mem_req, pc_mais4);
    end else begin
      passed++;
    end
    @(negedge clock);
    reset       = 1'b0;
    parar       = 1'b0;
    desvio      = 1'b0;
    desvio_alvo = 32'h0;
    mem_pronto  = 1'b0;
    spurious    = 1'b0;
    mem_en      = 1'b1;
    discard     = 1'b0;
    fresh       = 1'b1;
    cnt         = 0;
    fetch_pc    = 32'h0;
    exp_q.delete();
  endtask

  task automatic drain();
    mem_en = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 1'b0, 32'h0);
    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d words never delivered, required 0", exp_q.size());
    end else begin
      passed++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    lat = 0;
    step(1'b0, 1'b0, 32'h0);
    total++;
    if (obs_req !== 1'b1 || obs_end !== 32'h0 || obs_valida !== 1'b0) begin
      $display("FAIL first_fetch: got req=%b addr=%h valida=%b, required 1 00000000 0",
               obs_req, obs_end, obs_valida);
    end else begin
      passed++;
    end
    drain();
  endtask

  task automatic test_stream();
    do_reset();
    lat = 0;
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      total++;
      if (obs_valida !== 1'b1 || obs_instr !== tag(32'(4 * i)) || obs_pc !== 32'(4 * i)) begin
        $display("FAIL stream_%0d: got valida=%b instr=%h pc=%h, required 1 %h %h",
                 i, obs_valida, obs_instr, obs_pc, tag(32'(4 * i)), 32'(4 * i));
      end else begin
        passed++;
      end
    end
    drain();
  endtask

  task automatic test_latency();
    do_reset();
    lat = 3;
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      total++;
      if (i <= 4) begin
        if (obs_req !== 1'b1 || obs_end !== 32'h0 || obs_valida !== 1'b0) begin
          $display("FAIL latency_wait_%0d: got req=%b addr=%h valida=%b, required 1 00000000 0",
                   i, obs_req, obs_end, obs_valida);
        end else begin
          passed++;
        end
      end else begin
        if (obs_valida !== 1'b1 || obs_pc !== 32'h0) begin
          $display("FAIL latency_word: got valida=%b pc=%h, required 1 00000000", obs_valida, obs_pc);
        end else begin
          passed++;
        end
      end
    end
    drain();
  endtask

  task automatic test_stall();
    do_reset();
    lat = 0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    spurious = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    spurious = 1'b0;
    total++;
    if (obs_req !== 1'b0 || obs_valida !== 1'b1 || obs_instr !== tag(32'h4)) begin
      $display("FAIL stall_hold1: got req=%b valida=%b instr=%h, required 0 1 %h",
               obs_req, obs_valida, obs_instr, tag(32'h4));
    end else begin
      passed++;
    end
    step(1'b0, 1'b0, 32'h0);
    total++;
    if (obs_valida !== 1'b1 || obs_instr !== tag(32'h4) || obs_pc !== 32'h4) begin
      $display("FAIL stall_hold2: got valida=%b instr=%h pc=%h, required 1 %h 00000004",
               obs_valida, obs_instr, obs_pc, tag(32'h4));
    end else begin
      passed++;
    end
    step(1'b0, 1'b0, 32'h0);
    total++;
    if (obs_instr !== tag(32'h8) || obs_pc !== 32'h8 || obs_end !== 32'hC || obs_req !== 1'b1) begin
      $display("FAIL stall_release: got instr=%h pc=%h addr=%h req=%b, required %h 00000008 0000000c 1",
               obs_instr, obs_pc, obs_end, obs_req, tag(32'h8));
    end else begin
      passed++;
    end
    drain();
  endtask

  task automatic test_desvio();
    logic        d;
    logic [31:0] alvo;
    do_reset();
    lat = 3;
    for (int i = 1; i <= 13; i++) begin
      d    = (i == 2 || i == 6 || i == 7);
      alvo = (i == 2) ? 32'h0000_1003 : (i == 6) ? 32'h0000_3000 : 32'h0000_2004;
      step(1'b0, d, alvo);
      if (i == 3 || i == 7) begin
        total++;
        if (obs_req !== 1'b1 || obs_end !== ((i == 3) ? 32'h0 : 32'h1000) || obs_valida !== 1'b0) begin
          $display("FAIL descarte_hold_%0d: got req=%b addr=%h valida=%b", i, obs_req, obs_end, obs_valida);
        end else begin
          passed++;
        end
      end
      if (i == 5 || i == 9) begin
        total++;
        if (obs_end !== ((i == 5) ? 32'h1000 : 32'h2004) || obs_valida !== 1'b0) begin
          $display("FAIL desvio_target_%0d: got addr=%h valida=%b, required %h 0",
                   i, obs_end, obs_valida, (i == 5) ? 32'h1000 : 32'h2004);
        end else begin
          passed++;
        end
      end
      if (i == 13) begin
        total++;
        if (obs_valida !== 1'b1 || obs_pc !== 32'h2004) begin
          $display("FAIL desvio_word: got valida=%b pc=%h, required 1 00002004", obs_valida, obs_pc);
        end else begin
          passed++;
        end
      end
    end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 0;
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0);
    total++;
    if (obs_end !== 32'hFFFF_FFF8 || obs_valida !== 1'b0) begin
      $display("FAIL wrap_target: got addr=%h valida=%b, required fffffff8 0", obs_end, obs_valida);
    end else begin
      passed++;
    end
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    total++;
    if (obs_end !== 32'h0 || obs_pc !== 32'hFFFF_FFFC || obs_pc4 !== 32'h0) begin
      $display("FAIL wrap: got addr=%h pc=%h pc4=%h, required 00000000 fffffffc 00000000",
               obs_end, obs_pc, obs_pc4);
    end else begin
      passed++;
    end
    drain();
  endtask

  task automatic test_reset_segura();
    do_reset();
    lat = 0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    // DUT is now in SEGURA holding a live word
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    total++;
    if (obs_req !== 1'b1 || obs_end !== 32'h0) begin
      $display("FAIL restart_addr: got req=%b addr=%h, required 1 00000000", obs_req, obs_end);
    end else begin
      passed++;
    end
    step(1'b0, 1'b0, 32'h0);
    total++;
    if (obs_valida !== 1'b1 || obs_instr !== tag(32'h0) || obs_pc !== 32'h0) begin
      $display("FAIL restart_word: got valida=%b instr=%h pc=%h, required 1 %h 00000000",
               obs_valida, obs_instr, obs_pc, tag(32'h0));
    end else begin
      passed++;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic p;
    logic d;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      lat = $urandom_range(0, 2);
      p   = ($urandom_range(0, 3) == 0);
      d   = ($urandom_range(0, 15) == 0);
      step(p, d, $urandom);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_desvio();
    test_wrap();
    test_reset_segura();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port mem_endereco  output  32  word address of the outstanding request.
REQ-006 SHALL have port mem_pronto  input  1  memory returns mem_dado this cycle.
REQ-007 SHALL have port mem_dado  input  32  instruction word from memory.
REQ-008 SHALL have port parar  input  1  downstream stall; decoder cannot accept a new word.
REQ-009 SHALL have port desvio  input  1  redirect (taken branch/jump), one-cycle pulse.
REQ-010 SHALL have port desvio_alvo  input  32  redirect target address.
REQ-011 SHALL have port instrucao  output  32  registered instruction word feeding the field decoder.
REQ-012 SHALL have ports pc_atual and pc_mais4  output  32 each  address of instrucao and that address + 4.
REQ-013 SHALL have port valida  output  1  instrucao/pc_atual hold a live instruction.

Function
REQ-014 SHALL implement FSM states OCIOSO, BUSCA, SEGURA, DESCARTE.
REQ-015 OCIOSO: mem_req=0; unconditional transition to BUSCA next cycle.
REQ-016 BUSCA: mem_req=1, mem_endereco=pc; address SHALL stay stable until mem_pronto=1.
REQ-017 BUSCA, mem_pronto=1, parar=0, desvio=0: next edge instrucao<=mem_dado, pc_atual<=pc, valida<=1, pc<=pc+4; remain BUSCA (one word/cycle with zero-wait memory).
REQ-018 BUSCA, mem_pronto=1, parar=1, desvio=0: mem_dado captured into internal buffer, pc<=pc+4, go SEGURA; outputs unchanged.
REQ-019 SEGURA: mem_req=0; when parar=0 and desvio=0, buffer transferred to outputs (valida<=1, pc_atual<=buffer address), go BUSCA.
REQ-020 parar=1 in any state SHALL hold instrucao, pc_atual, valida unchanged.
REQ-021 desvio=1 SHALL take priority over parar and mem_pronto: next edge valida<=0, pc<={desvio_alvo[31:2],2'b00}.
REQ-022 desvio=1 in BUSCA with mem_pronto=1, or in SEGURA: returned/buffered word discarded; go BUSCA.
REQ-023 desvio=1 in BUSCA with mem_pronto=0: go DESCARTE; mem_req stays 1 at the old address until mem_pronto, word discarded, then BUSCA at target.
REQ-024 desvio=1 while in DESCARTE SHALL update pc to the new target; state unchanged.
REQ-025 pc+4 and pc_mais4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-026 pc_mais4 SHALL equal pc_atual + 4 combinationally.
REQ-027 mem_pronto outside BUSCA/DESCARTE SHALL be ignored.

Reset
REQ-028 reset=1 SHALL immediately force: state OCIOSO, pc=PC_RESET, mem_req=0, valida=0, instrucao=0, pc_atual=0, buffer cleared.
REQ-029 reset asserted mid-request SHALL abandon the request; a late mem_pronto after reset release SHALL be ignored unless in BUSCA.

Verification
REQ-030 Reset release, mem_pronto tied 1, mem_dado=addr-tag -> instrucao tags 0,4,8 on consecutive cycles, valida=1 from 2nd cycle after OCIOSO.
REQ-031 mem_pronto delayed 3 cycles -> mem_endereco constant for 3 cycles, valida=0 until word, then pc_atual=0x0.
REQ-032 parar=1 for 2 cycles while word 0x8 returns -> outputs hold word 0x4; on parar=0, instrucao=word 0x8 next edge, no word lost or duplicated.
REQ-033 desvio=1, target 0x0000_1003, with request pending -> DESCARTE, old word dropped, next mem_endereco=0x0000_1000, valida=0 until it returns.
REQ-034 pc=0xFFFF_FFFC fetched -> next mem_endereco=0x0000_0000, pc_mais4=0x0000_0000.
REQ-035 reset pulsed while in SEGURA -> all outputs zero immediately, fetch restarts at PC_RESET.
